// File: rtl/rv32i_instr_encoder.sv
// RV32I program loader: packs one mnemonic plus operands per request into a 32-bit
// instruction word and writes it to instruction memory at a sequential write pointer.
package fe_pkg;
  typedef enum logic [5:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    JAL, JALR, ECALL, EBREAK, LUI, AUIPC, NULL
  } RV32I_INSTRUCTION_MNEMONIC_t;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } RV32I_OPCODE_t;
endpackage

module rv32i_instr_encoder
  import fe_pkg::*;
#(
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int BASE_ADDR       = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  RV32I_INSTRUCTION_MNEMONIC_t   req_mnemonic,
  input  logic [4:0]                    req_rd,
  input  logic [4:0]                    req_rs1,
  input  logic [4:0]                    req_rs2,
  input  logic [31:0]                   req_imm,
  input  logic                          load_addr_en,
  input  logic [IMEM_ADDR_WIDTH-1:0]    load_addr,
  output logic                          imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0]    imem_addr,
  output logic [31:0]                   imem_wdata,
  input  logic                          imem_ready,
  output logic                          err_valid,
  output logic [1:0]                    err_code,
  output logic [IMEM_ADDR_WIDTH:0]      instr_count
);

  typedef enum logic [1:0] {IDLE, ENCODE, WRITE, ERROR} state_t;

  localparam logic [IMEM_ADDR_WIDTH:0] COUNT_MAX = '1;

  state_t                      state, state_next;
  RV32I_INSTRUCTION_MNEMONIC_t mn;
  logic [4:0]                  rd, rs1, rs2;
  logic [31:0]                 imm;
  logic [IMEM_ADDR_WIDTH-1:0]  wptr;
  logic [31:0]                 enc_word;
  logic [1:0]                  enc_err;
  logic [2:0]                  f3;
  logic                        alt;
  logic                        accept;
  logic                        fits12, fits13, fits21, shamt_ok, upper_ok;

  assign accept    = req_valid & req_ready;
  assign imem_addr = wptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ENCODE;
      ENCODE:  state_next = (enc_err == 2'b00) ? WRITE : ERROR;
      WRITE:   if (imem_ready) state_next = IDLE;
      ERROR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !load_addr_en;
    imem_we   = (state == WRITE);
    err_valid = (state == ERROR);
  end

  // Sign-extension tests: the bits above each field must all equal its sign bit.
  assign fits12   = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13   = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits21   = (imm[31:20] == '0) || (imm[31:20] == '1);
  assign shamt_ok = (imm[31:5] == '0);
  assign upper_ok = (imm[31:20] == '0);
  assign alt      = (mn == SUB) || (mn == SRA) || (mn == SRAI);

  always_comb begin
    f3 = 3'b000;
    case (mn)
      SLL, SLLI, LH, SH, BNE:             f3 = 3'b001;
      SLT, SLTI, LW, SW:                  f3 = 3'b010;
      SLTU, SLTIU:                        f3 = 3'b011;
      XOR, XORI, LBU, BLT:                f3 = 3'b100;
      SRL, SRA, SRLI, SRAI, LHU, BGE:     f3 = 3'b101;
      OR, ORI, BLTU:                      f3 = 3'b110;
      AND, ANDI, BGEU:                    f3 = 3'b111;
      default:                            f3 = 3'b000;
    endcase
  end

  // Misalignment is checked before range so that code 11 outranks code 10.
  always_comb begin
    enc_word = 32'h0;
    enc_err  = 2'b00;
    case (mn)
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND:
        enc_word = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, OPC_OP};
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI: begin
        enc_word = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
        if (!fits12) enc_err = 2'b10;
      end
      SLLI, SRLI, SRAI: begin
        enc_word = {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, OPC_OP_IMM};
        if (!shamt_ok) enc_err = 2'b10;
      end
      LB, LH, LW, LBU, LHU: begin
        enc_word = {imm[11:0], rs1, f3, rd, OPC_LOAD};
        if (!fits12) enc_err = 2'b10;
      end
      JALR: begin
        enc_word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
        if (!fits12) enc_err = 2'b10;
      end
      SB, SH, SW: begin
        enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
        if (!fits12) enc_err = 2'b10;
      end
      BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
        if (imm[0])       enc_err = 2'b11;
        else if (!fits13) enc_err = 2'b10;
      end
      JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        if (imm[0])       enc_err = 2'b11;
        else if (!fits21) enc_err = 2'b10;
      end
      ECALL:  enc_word = 32'h00000073;
      EBREAK: enc_word = 32'h00100073;
      LUI: begin
        enc_word = {imm[19:0], rd, OPC_LUI};
        if (!upper_ok) enc_err = 2'b10;
      end
      AUIPC: begin
        enc_word = {imm[19:0], rd, OPC_AUIPC};
        if (!upper_ok) enc_err = 2'b10;
      end
      default: enc_err = 2'b01;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mn          <= NULL;
      rd          <= '0;
      rs1         <= '0;
      rs2         <= '0;
      imm         <= '0;
      imem_wdata  <= '0;
      err_code    <= '0;
      wptr        <= IMEM_ADDR_WIDTH'(BASE_ADDR);
      instr_count <= '0;
    end else begin
      if (accept) begin
        mn  <= req_mnemonic;
        rd  <= req_rd;
        rs1 <= req_rs1;
        rs2 <= req_rs2;
        imm <= req_imm;
      end
      if ((state == IDLE) && load_addr_en) wptr <= load_addr;
      if (state == ENCODE) begin
        if (enc_err == 2'b00) imem_wdata <= enc_word;
        else                  err_code   <= enc_err;
      end
      if ((state == WRITE) && imem_ready) begin
        wptr <= wptr + IMEM_ADDR_WIDTH'(1);
        if (instr_count != COUNT_MAX) instr_count <= instr_count + (IMEM_ADDR_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Randomized bench for rv32i_instr_encoder: every request is predicted by a
// format-table reference model, plus directed handshake, wrap and reset scenarios.
module tb_rv32i_instr_encoder;
  import fe_pkg::*;

  localparam int W     = 10;
  localparam int BASE  = 0;
  localparam int DEPTH = 1 << W;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        req_valid = 1'b0;
  logic                        req_ready;
  RV32I_INSTRUCTION_MNEMONIC_t req_mnemonic = NULL;
  logic [4:0]                  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0]                 req_imm = '0;
  logic                        load_addr_en = 1'b0;
  logic [W-1:0]                load_addr = '0;
  logic                        imem_we;
  logic [W-1:0]                imem_addr;
  logic [31:0]                 imem_wdata;
  logic                        imem_ready = 1'b0;
  logic                        err_valid;
  logic [1:0]                  err_code;
  logic [W:0]                  instr_count;

  int          checks = 0;
  int          errors = 0;
  int          exp_ptr = BASE;
  int          exp_count = 0;
  logic [1:0]  exp_code = 2'b00;
  logic [31:0] dut_word;

  rv32i_instr_encoder #(.IMEM_ADDR_WIDTH(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_mnemonic(req_mnemonic), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm(req_imm), .load_addr_en(load_addr_en), .load_addr(load_addr),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .err_valid(err_valid), .err_code(err_code),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference: look up format/opcode/funct fields per mnemonic, then pack with arithmetic.
  function automatic void refModel(input RV32I_INSTRUCTION_MNEMONIC_t mn, input int rd, input int rs1,
                                   input int rs2, input int imm, output logic [31:0] w, output logic [1:0] code);
    byte         fmt;
    int          opc, f3, f7;
    longint      v;
    logic [31:0] u;
    fmt = "X"; opc = 0; f3 = 0; f7 = 0; v = imm; u = imm; w = '0; code = 2'b00;
    case (mn)
      ADD:    begin fmt = "R"; opc = 'h33; f3 = 0; end
      SUB:    begin fmt = "R"; opc = 'h33; f3 = 0; f7 = 'h20; end
      SLL:    begin fmt = "R"; opc = 'h33; f3 = 1; end
      SLT:    begin fmt = "R"; opc = 'h33; f3 = 2; end
      SLTU:   begin fmt = "R"; opc = 'h33; f3 = 3; end
      XOR:    begin fmt = "R"; opc = 'h33; f3 = 4; end
      SRL:    begin fmt = "R"; opc = 'h33; f3 = 5; end
      SRA:    begin fmt = "R"; opc = 'h33; f3 = 5; f7 = 'h20; end
      OR:     begin fmt = "R"; opc = 'h33; f3 = 6; end
      AND:    begin fmt = "R"; opc = 'h33; f3 = 7; end
      ADDI:   begin fmt = "I"; opc = 'h13; f3 = 0; end
      SLTI:   begin fmt = "I"; opc = 'h13; f3 = 2; end
      SLTIU:  begin fmt = "I"; opc = 'h13; f3 = 3; end
      XORI:   begin fmt = "I"; opc = 'h13; f3 = 4; end
      ORI:    begin fmt = "I"; opc = 'h13; f3 = 6; end
      ANDI:   begin fmt = "I"; opc = 'h13; f3 = 7; end
      SLLI:   begin fmt = "H"; opc = 'h13; f3 = 1; end
      SRLI:   begin fmt = "H"; opc = 'h13; f3 = 5; end
      SRAI:   begin fmt = "H"; opc = 'h13; f3 = 5; f7 = 'h20; end
      LB:     begin fmt = "I"; opc = 'h03; f3 = 0; end
      LH:     begin fmt = "I"; opc = 'h03; f3 = 1; end
      LW:     begin fmt = "I"; opc = 'h03; f3 = 2; end
      LBU:    begin fmt = "I"; opc = 'h03; f3 = 4; end
      LHU:    begin fmt = "I"; opc = 'h03; f3 = 5; end
      SB:     begin fmt = "S"; opc = 'h23; f3 = 0; end
      SH:     begin fmt = "S"; opc = 'h23; f3 = 1; end
      SW:     begin fmt = "S"; opc = 'h23; f3 = 2; end
      BEQ:    begin fmt = "B"; opc = 'h63; f3 = 0; end
      BNE:    begin fmt = "B"; opc = 'h63; f3 = 1; end
      BLT:    begin fmt = "B"; opc = 'h63; f3 = 4; end
      BGE:    begin fmt = "B"; opc = 'h63; f3 = 5; end
      BLTU:   begin fmt = "B"; opc = 'h63; f3 = 6; end
      BGEU:   begin fmt = "B"; opc = 'h63; f3 = 7; end
      JAL:    begin fmt = "J"; opc = 'h6F; end
      JALR:   begin fmt = "I"; opc = 'h67; f3 = 0; end
      ECALL:  fmt = "E";
      EBREAK: fmt = "F";
      LUI:    begin fmt = "U"; opc = 'h37; end
      AUIPC:  begin fmt = "U"; opc = 'h17; end
      default: fmt = "X";
    endcase
    case (fmt)
      "R": w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
      "I": begin
        if (v < -2048 || v > 2047) code = 2'b10;
        w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
      end
      "H": begin
        if (v < 0 || v > 31) code = 2'b10;
        w = (f7 << 25) | ((u & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
      end
      "S": begin
        if (v < -2048 || v > 2047) code = 2'b10;
        w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((u & 32'h1F) << 7) | opc;
      end
      "B": begin
        if (v % 2 != 0) code = 2'b11;
        else if (v < -4096 || v > 4094) code = 2'b10;
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15) |
            (f3 << 12) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | opc;
      end
      "J": begin
        if (v % 2 != 0) code = 2'b11;
        else if (v < -1048576 || v > 1048574) code = 2'b10;
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20) |
            (((u >> 12) & 32'hFF) << 12) | (rd << 7) | opc;
      end
      "U": begin
        if (v < 0 || v > 1048575) code = 2'b10;
        w = ((u & 32'hFFFFF) << 12) | (rd << 7) | opc;
      end
      "E": w = 32'h00000073;
      "F": w = 32'h00100073;
      default: code = 2'b01;
    endcase
  endfunction

  function automatic int randImm();
    int bnd[18] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                    31, 32, -1, 0, 1048574, 1048575, -1048576, -1048578, 1048576};
    case ($urandom_range(0, 4))
      0:       return int'($urandom_range(0, 127)) - 64;
      1:       return int'($urandom_range(0, 4095)) - 2048;
      2:       return bnd[$urandom_range(0, 17)];
      3:       return int'($urandom);
      default: return (int'($urandom_range(0, 8191)) - 4096) & ~1;
    endcase
  endfunction

  task automatic applyStimulus(input RV32I_INSTRUCTION_MNEMONIC_t mn, input int rd, input int rs1,
                               input int rs2, input int imm, input int stall);
    logic [31:0] w;
    logic [1:0]  c;
    refModel(mn, rd, rs1, rs2, imm, w, c);
    @(negedge clk);
    req_valid = 1'b1; req_mnemonic = mn;
    req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2); req_imm = imm;
    #1 checkOutput("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("encode_no_we", {31'b0, imem_we}, 32'd0);
    @(negedge clk);
    if (c != 2'b00) begin
      exp_code = c;
      checkOutput("err_valid", {31'b0, err_valid}, 32'd1);
      checkOutput("err_code", {30'b0, err_code}, {30'b0, c});
      checkOutput("err_no_we", {31'b0, imem_we}, 32'd0);
      @(negedge clk);
      checkOutput("err_pulse_end", {31'b0, err_valid}, 32'd0);
      checkOutput("err_code_hold", {30'b0, err_code}, {30'b0, exp_code});
      checkOutput("err_ptr_kept", 32'(imem_addr), exp_ptr);
      checkOutput("err_count_kept", 32'(instr_count), exp_count);
    end else begin
      checkOutput("we_at_accept_plus2", {31'b0, imem_we}, 32'd1);
      checkOutput("write_addr", 32'(imem_addr), exp_ptr);
      checkOutput("write_data", imem_wdata, w);
      checkOutput("write_no_err", {31'b0, err_valid}, 32'd0);
      dut_word = imem_wdata;
      if (stall > 0) begin
        load_addr_en = 1'b1;
        load_addr = W'($urandom);
      end
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        checkOutput("stall_we", {31'b0, imem_we}, 32'd1);
        checkOutput("stall_addr", 32'(imem_addr), exp_ptr);
        checkOutput("stall_data", imem_wdata, w);
      end
      load_addr_en = 1'b0;
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      exp_ptr = (exp_ptr + 1) % DEPTH;
      if (exp_count < 2 * DEPTH - 1) exp_count++;
      checkOutput("done_we_low", {31'b0, imem_we}, 32'd0);
      checkOutput("ptr_advance", 32'(imem_addr), exp_ptr);
      checkOutput("count", 32'(instr_count), exp_count);
    end
  endtask

  task automatic loadAddr(input int a, input bit with_valid);
    @(negedge clk);
    load_addr_en = 1'b1; load_addr = W'(a);
    req_valid = with_valid; req_mnemonic = ADDI; req_imm = 32'd1;
    #1 checkOutput("load_ready_low", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    load_addr_en = 1'b0; req_valid = 1'b0;
    exp_ptr = a;
    checkOutput("load_ptr", 32'(imem_addr), exp_ptr);
    repeat (2) @(negedge clk);
    checkOutput("load_no_accept_we", {31'b0, imem_we}, 32'd0);
    checkOutput("load_no_accept_err", {31'b0, err_valid}, 32'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = BASE; exp_count = 0; exp_code = 2'b00;
  endtask

  initial begin
    $display("[TB] starting rv32i_instr_encoder bench");
    repeat (2) @(negedge clk);
    checkOutput("rst_we", {31'b0, imem_we}, 32'd0);
    checkOutput("rst_err_valid", {31'b0, err_valid}, 32'd0);
    checkOutput("rst_err_code", {30'b0, err_code}, 32'd0);
    checkOutput("rst_wdata", imem_wdata, 32'd0);
    checkOutput("rst_count", 32'(instr_count), 32'd0);
    checkOutput("rst_addr", 32'(imem_addr), BASE);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);

    applyStimulus(ADDI, 1, 0, 0, 5, 0);
    checkOutput("addi_word", dut_word, 32'h00500093);

    doReset();
    applyStimulus(SUB, 3, 1, 2, 0, 0);
    checkOutput("sub_word", dut_word, 32'h402081B3);
    applyStimulus(BEQ, 0, 1, 2, -8, 0);
    checkOutput("beq_word", dut_word, 32'hFE208CE3);

    applyStimulus(ADDI, 1, 0, 0, 2048, 0);
    checkOutput("addi_range_code", {30'b0, err_code}, 32'd2);
    applyStimulus(JAL, 1, 0, 0, 3, 0);
    checkOutput("jal_misalign_code", {30'b0, err_code}, 32'd3);
    applyStimulus(NULL, 1, 2, 3, 0, 0);
    checkOutput("null_code", {30'b0, err_code}, 32'd1);
    applyStimulus(AND, 7, 8, 9, 0, 3);

    loadAddr(DEPTH - 1, 1'b1);
    applyStimulus(SW, 0, 2, 5, 4, 0);
    checkOutput("sw_word_top", dut_word, 32'h00512223);
    applyStimulus(SW, 0, 2, 5, 4, 1);
    checkOutput("sw_word_wrap", dut_word, 32'h00512223);

    for (int n = 0; n < 250; n++) begin
      RV32I_INSTRUCTION_MNEMONIC_t mn;
      mn = RV32I_INSTRUCTION_MNEMONIC_t'(6'($urandom_range(0, 44)));
      if ($urandom_range(0, 19) == 0) loadAddr(int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)));
      applyStimulus(mn, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), randImm(), int'($urandom_range(0, 2)));
    end

    // Reset asserted while a write is stalled on imem_ready.
    @(negedge clk);
    req_valid = 1'b1; req_mnemonic = ADDI; req_rd = 5'd1; req_rs1 = 5'd0; req_imm = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_we", {31'b0, imem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_mid_we_drop", {31'b0, imem_we}, 32'd0);
    checkOutput("rst_mid_addr", 32'(imem_addr), BASE);
    checkOutput("rst_mid_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = BASE; exp_count = 0; exp_code = 2'b00;
    @(negedge clk);
    checkOutput("rst_mid_idle", {31'b0, req_ready}, 32'd1);
    applyStimulus(ADDI, 1, 0, 0, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
